piso_serializer_8bit: RTL and testbench

Parallel-in/serial-out transmitter that feeds the 8-bit serial-in/parallel-out shift register. Accepts a WIDTH-bit word over a valid/ready handshake and emits it on `sout` one bit per `clk`, LSB first, so the word appears intact on the downstream register's `Po[7:0]` after WIDTH edges. Provides a `word_done` strobe so the consumer knows when its parallel output holds a complete word; an optional idle gap separates words.

---
 rtl/serial_pkg.sv | 13 +
 rtl/piso_serializer_8bit_bit_counter.sv | 27 ++
 rtl/piso_serializer_8bit.sv | 130 +++++++++++++
 tb/tb_piso_serializer_8bit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word path (serializer and downstream framing).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int   SER_WIDTH_DEFAULT      = 8;
  localparam logic SER_IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/piso_serializer_8bit_bit_counter.sv
// Loadable up-counter, cleared to zero on load, with a terminal-count flag.
module bit_counter #(
  parameter int CNT_W = 3,
  parameter int TERM  = 7
) (
  input  logic clk,
  input  logic rs,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TERM));

endmodule

// File: rtl/piso_serializer_8bit.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, LSB-first serial output,
// word_done on the last bit and an optional idle gap between words.
//
// state | meaning
// IDLE  | waiting for a word, din_ready high
// SHIFT | driving holding[0] on sout, one bit per clock
// GAP   | sout at idle level for GAP cycles before accepting the next word
module piso_serializer_8bit
  import serial_pkg::*;
#(
  parameter int   WIDTH      = SER_WIDTH_DEFAULT,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = SER_IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             word_done,
  output logic             busy
);

  localparam int BIT_W  = $clog2(WIDTH);
  localparam int GAP_TC = (GAP > 0) ? GAP - 1 : 0;

  ser_state_t       r_state;
  ser_state_t       w_next_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_next_hold;
  logic             r_sout;
  logic             r_sout_en;
  logic             r_word_done;
  logic             r_busy;
  logic             w_hs;
  logic             w_bit_clr;
  logic             w_bit_inc;
  logic             w_bit_pre_last;
  logic             w_gap_clr;
  logic             w_gap_inc;
  logic             w_gap_tc;

  // Bit counter flags the second-to-last bit so word_done can be registered
  // into the last-bit cycle; the last-bit cycle itself is then r_word_done.
  bit_counter #(.CNT_W(BIT_W), .TERM(WIDTH - 2)) u_bit_cnt (
    .clk  (clk),
    .rs   (rs),
    .i_clr(w_bit_clr),
    .i_inc(w_bit_inc),
    .o_tc (w_bit_pre_last)
  );

  bit_counter #(.CNT_W(4), .TERM(GAP_TC)) u_gap_cnt (
    .clk  (clk),
    .rs   (rs),
    .i_clr(w_gap_clr),
    .i_inc(w_gap_inc),
    .o_tc (w_gap_tc)
  );

  assign din_ready = rs & ((r_state == serial_pkg::IDLE) |
                           ((GAP == 0) & (r_state == serial_pkg::SHIFT) & r_word_done));
  assign w_hs      = din_valid & din_ready;

  always_comb begin
    w_next_state = r_state;
    w_next_hold  = r_hold;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_gap_clr    = 1'b0;
    w_gap_inc    = 1'b0;
    case (r_state)
      serial_pkg::IDLE: begin
        if (w_hs) begin
          w_next_state = serial_pkg::SHIFT;
          w_next_hold  = din;
          w_bit_clr    = 1'b1;
        end
      end
      serial_pkg::SHIFT: begin
        w_next_hold = r_hold >> 1;
        if (!r_word_done) begin
          w_bit_inc = 1'b1;
        end else if (GAP > 0) begin
          w_next_state = serial_pkg::GAP;
          w_gap_clr    = 1'b1;
        end else if (w_hs) begin
          w_next_hold = din;
          w_bit_clr   = 1'b1;
        end else begin
          w_next_state = serial_pkg::IDLE;
        end
      end
      serial_pkg::GAP: begin
        w_gap_inc = 1'b1;
        if (w_gap_tc) begin
          w_next_state = serial_pkg::IDLE;
        end
      end
      default: w_next_state = serial_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_state     <= serial_pkg::IDLE;
      r_hold      <= '0;
      r_sout      <= IDLE_LEVEL;
      r_sout_en   <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_hold      <= w_next_hold;
      r_sout      <= (w_next_state == serial_pkg::SHIFT) ? w_next_hold[0] : IDLE_LEVEL;
      r_sout_en   <= (w_next_state == serial_pkg::SHIFT);
      r_word_done <= (w_next_state == serial_pkg::SHIFT) & (r_state == serial_pkg::SHIFT) &
                     w_bit_pre_last;
      r_busy      <= (w_next_state != serial_pkg::IDLE);
    end
  end

  assign sout      = r_sout;
  assign sout_en   = r_sout_en;
  assign word_done = r_word_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Bench for piso_serializer_8bit: GAP=0 and GAP=3 instances, each feeding a downstream SIPO model.
module tb_piso_serializer_8bit;

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic [7:0] din0 = 8'h00, din3 = 8'h00;
  logic       v0 = 1'b0, v3 = 1'b0;
  logic       rdy0, sout0, en0, wd0, busy0;
  logic       rdy3, sout3, en3, wd3, busy3;
  logic [7:0] po0 = 8'h00, po3 = 8'h00;
  int         n_cmp = 0;
  int         n_fail = 0;

  piso_serializer_8bit #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rs(rs), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .sout(sout0), .sout_en(en0), .word_done(wd0), .busy(busy0)
  );

  piso_serializer_8bit #(.WIDTH(8), .GAP(3), .IDLE_LEVEL(1'b0)) dut3 (
    .clk(clk), .rs(rs), .din(din3), .din_valid(v3), .din_ready(rdy3),
    .sout(sout3), .sout_en(en3), .word_done(wd3), .busy(busy3)
  );

  initial forever #5 clk = ~clk;

  // downstream 8-bit SIPO: LSB-first bits enter at the top and move toward bit 0
  always @(posedge clk) begin
    if (en0) po0 <= {sout0, po0[7:1]};
    if (en3) po3 <= {sout3, po3[7:1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rs = 1'b0; v0 = 1'b0; v3 = 1'b0;
    repeat (3) step();
    n_cmp++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got=%b exp=0", rdy0); end
    n_cmp++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL rst_ready3 got=%b exp=0", rdy3); end
    n_cmp++; if ({sout0, en0, wd0, busy0} !== 4'b0000) begin n_fail++; $display("FAIL rst_outs0 got=%b exp=0000", {sout0, en0, wd0, busy0}); end
    n_cmp++; if ({sout3, en3, wd3, busy3} !== 4'b0000) begin n_fail++; $display("FAIL rst_outs3 got=%b exp=0000", {sout3, en3, wd3, busy3}); end
    rs = 1'b1;
    step();
    n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL idle_ready0 got=%b exp=1", rdy0); end
    n_cmp++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL idle_ready3 got=%b exp=1", rdy3); end
    n_cmp++; if ({sout0, en0, wd0, busy0} !== 4'b0000) begin n_fail++; $display("FAIL idle_outs0 got=%b exp=0000", {sout0, en0, wd0, busy0}); end
  endtask

  // sends w on dut0 from IDLE, checking every bit, then the downstream word
  task automatic send_check0(input logic [7:0] w, input string tag);
    logic exp_last;
    din0 = w; v0 = 1'b1;
    n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL %s_hs_ready got=%b exp=1", tag, rdy0); end
    step();
    v0 = 1'b0; din0 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      exp_last = (i == 7);
      n_cmp++; if (sout0 !== w[i]) begin n_fail++; $display("FAIL %s_sout bit%0d got=%b exp=%b", tag, i, sout0, w[i]); end
      n_cmp++; if ({en0, busy0} !== 2'b11) begin n_fail++; $display("FAIL %s_en_busy bit%0d got=%b exp=11", tag, i, {en0, busy0}); end
      n_cmp++; if (wd0 !== exp_last) begin n_fail++; $display("FAIL %s_word_done bit%0d got=%b exp=%b", tag, i, wd0, exp_last); end
      n_cmp++; if (rdy0 !== exp_last) begin n_fail++; $display("FAIL %s_ready bit%0d got=%b exp=%b", tag, i, rdy0, exp_last); end
      step();
    end
    n_cmp++; if (po0 !== w) begin n_fail++; $display("FAIL %s_po got=%h exp=%h", tag, po0, w); end
    n_cmp++; if ({sout0, en0, wd0, busy0, rdy0} !== 5'b00001) begin n_fail++; $display("FAIL %s_back_idle got=%b exp=00001", tag, {sout0, en0, wd0, busy0, rdy0}); end
  endtask

  task automatic test_single();
    send_check0(8'hA5, "single");
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    logic        exp_last;
    s = {8'hC3, 8'h3C};
    din0 = 8'h3C; v0 = 1'b1;
    step();
    din0 = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      exp_last = (i == 7) || (i == 15);
      if (i == 8) begin
        v0 = 1'b0;
        n_cmp++; if (po0 !== 8'h3C) begin n_fail++; $display("FAIL b2b_po_first got=%h exp=3c", po0); end
      end
      n_cmp++; if (sout0 !== s[i]) begin n_fail++; $display("FAIL b2b_sout bit%0d got=%b exp=%b", i, sout0, s[i]); end
      n_cmp++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble bit%0d sout_en got=%b exp=1", i, en0); end
      n_cmp++; if (wd0 !== exp_last) begin n_fail++; $display("FAIL b2b_word_done bit%0d got=%b exp=%b", i, wd0, exp_last); end
      n_cmp++; if (rdy0 !== exp_last) begin n_fail++; $display("FAIL b2b_ready bit%0d got=%b exp=%b", i, rdy0, exp_last); end
      step();
    end
    n_cmp++; if (po0 !== 8'hC3) begin n_fail++; $display("FAIL b2b_po_second got=%h exp=c3", po0); end
    n_cmp++; if ({en0, busy0, rdy0} !== 3'b001) begin n_fail++; $display("FAIL b2b_back_idle got=%b exp=001", {en0, busy0, rdy0}); end
  endtask

  task automatic test_gap();
    logic [15:0] s;
    logic        exp_last;
    s = {8'h01, 8'hFF};
    din3 = 8'hFF; v3 = 1'b1;
    n_cmp++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL gap_hs_ready got=%b exp=1", rdy3); end
    step();
    din3 = 8'h01;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        exp_last = (i == 7);
        n_cmp++; if (sout3 !== s[w*8+i]) begin n_fail++; $display("FAIL gap_sout w%0d bit%0d got=%b exp=%b", w, i, sout3, s[w*8+i]); end
        n_cmp++; if ({en3, busy3, rdy3} !== 3'b110) begin n_fail++; $display("FAIL gap_shift_flags w%0d bit%0d got=%b exp=110", w, i, {en3, busy3, rdy3}); end
        n_cmp++; if (wd3 !== exp_last) begin n_fail++; $display("FAIL gap_word_done w%0d bit%0d got=%b exp=%b", w, i, wd3, exp_last); end
        step();
      end
      for (int g = 0; g < 3; g++) begin
        n_cmp++; if ({sout3, en3, rdy3, busy3, wd3} !== 5'b00010) begin n_fail++; $display("FAIL gap_idle w%0d cyc%0d got=%b exp=00010", w, g, {sout3, en3, rdy3, busy3, wd3}); end
        step();
      end
      n_cmp++; if ({rdy3, busy3} !== 2'b10) begin n_fail++; $display("FAIL gap_after w%0d got=%b exp=10", w, {rdy3, busy3}); end
      n_cmp++; if (po3 !== s[w*8 +: 8]) begin n_fail++; $display("FAIL gap_po w%0d got=%h exp=%h", w, po3, s[w*8 +: 8]); end
      if (w == 0) begin
        step();
        v3 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'h0F;
    din0 = w; v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sout0 !== w[i]) begin n_fail++; $display("FAIL rmid_sout bit%0d got=%b exp=%b", i, sout0, w[i]); end
      if (i < 3) step();
    end
    rs = 1'b0;
    #1;
    n_cmp++; if ({sout0, en0, wd0, busy0, rdy0} !== 5'b00000) begin n_fail++; $display("FAIL rmid_abort got=%b exp=00000", {sout0, en0, wd0, busy0, rdy0}); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if ({en0, wd0} !== 2'b00) begin n_fail++; $display("FAIL rmid_hold cyc%0d got=%b exp=00", c, {en0, wd0}); end
    end
    rs = 1'b1;
    step();
    send_check0(8'h81, "after_rst");
  endtask

  task automatic test_ignore_valid();
    send_check0(8'($urandom), "pre_ignore");
    begin
      logic [7:0] w;
      logic       exp_last;
      w = 8'($urandom);
      din0 = w; v0 = 1'b1;
      step();
      v0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
        exp_last = (i == 7);
        n_cmp++; if (sout0 !== w[i]) begin n_fail++; $display("FAIL ignore_sout bit%0d got=%b exp=%b", i, sout0, w[i]); end
        n_cmp++; if (wd0 !== exp_last) begin n_fail++; $display("FAIL ignore_word_done bit%0d got=%b exp=%b", i, wd0, exp_last); end
        if (i >= 1 && i <= 5) begin v0 = 1'b1; din0 = 8'($urandom); end
        else v0 = 1'b0;
        step();
      end
      n_cmp++; if (po0 !== w) begin n_fail++; $display("FAIL ignore_po got=%h exp=%h", po0, w); end
      n_cmp++; if ({en0, busy0, rdy0} !== 3'b001) begin n_fail++; $display("FAIL ignore_back_idle got=%b exp=001", {en0, busy0, rdy0}); end
    end
  endtask

  // random words, random idle spacing, random noise on valid, random gapless follow-ons
  task automatic test_random();
    logic [7:0] w, nxt;
    logic       pending, b2b, exp_last;
    int         idle;
    w = 8'($urandom); pending = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (!pending) begin
        idle = $urandom_range(0, 3);
        for (int c = 0; c < idle; c++) begin
          n_cmp++; if ({en0, busy0, rdy0} !== 3'b001) begin n_fail++; $display("FAIL rand_idle w%0d got=%b exp=001", n, {en0, busy0, rdy0}); end
          step();
        end
        din0 = w; v0 = 1'b1;
        n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL rand_hs_ready w%0d got=%b exp=1", n, rdy0); end
        step();
      end
      v0 = 1'b0; din0 = 8'($urandom);
      b2b = (n < 23) && ($urandom_range(0, 1) == 1);
      nxt = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        exp_last = (i == 7);
        n_cmp++; if ({sout0, en0} !== {w[i], 1'b1}) begin n_fail++; $display("FAIL rand_sout w%0d bit%0d got=%b exp=%b", n, i, {sout0, en0}, {w[i], 1'b1}); end
        n_cmp++; if ({wd0, rdy0} !== {exp_last, exp_last}) begin n_fail++; $display("FAIL rand_done_ready w%0d bit%0d got=%b exp=%b", n, i, {wd0, rdy0}, {exp_last, exp_last}); end
        if (i == 7 && b2b) begin din0 = nxt; v0 = 1'b1; end
        else if (i < 6) begin v0 = 1'($urandom_range(0, 1)); din0 = 8'($urandom); end
        else v0 = 1'b0;
        step();
      end
      n_cmp++; if (po0 !== w) begin n_fail++; $display("FAIL rand_po w%0d got=%h exp=%h", n, po0, w); end
      pending = b2b;
      w = nxt;
    end
    v0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_ignore_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
